// File: rtl/if_fetch_master.sv
// -----------------------------------------------------------------------------
// if_fetch_master
//
// Instruction-memory read master that sits directly upstream of the IF stage.
// It issues one single-beat AXI read at the IF stage's current PC and buffers
// the returned word. It then presents that word to the IF stage as inst_o,
// together with im_done_o. The pipeline controller combines im_done_o with the
// data-side done flag to form the IF/ID advance.
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   pc_i          fetch PC from the IF stage (stable while im_done_o=0)
//   pipe_adv_i    global pipeline advance (only meaningful in HOLD)
//   arid_o        constant FETCH_ID
//   araddr_o      word-aligned pc_i while arvalid_o=1, else 0
//   arvalid_o     read address valid        arready_i  read address ready
//   rdata_i       read data                 rresp_i    read response
//   rlast_i       last beat (ignored)       rvalid_i   read data valid
//   rready_o      read data ready
//   inst_o        held instruction          im_done_o  inst_o valid for pc_i
//   im_err_o      held word came from a non-OKAY response
//   fetch_cnt_o   completed-fetch counter (wraps)
//   state_o       current FSM state, for observation only
//
// Handshake semantics (both AXI channels): a transfer happens on a rising edge
// where valid and ready are both 1. While arvalid_o=1, arvalid_o and araddr_o
// hold until that edge. No more than one read is ever outstanding.
// -----------------------------------------------------------------------------
module if_fetch_master #(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter int              ID_W     = 4,
  parameter logic [ID_W-1:0] FETCH_ID = '0,
  parameter logic [DATA_W-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              pipe_adv_i,
  output logic [ID_W-1:0]   arid_o,
  output logic [ADDR_W-1:0] araddr_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        rresp_i,
  input  logic              rlast_i,
  input  logic              rvalid_i,
  output logic              rready_o,
  output logic [DATA_W-1:0] inst_o,
  output logic              im_done_o,
  output logic              im_err_o,
  output logic [31:0]       fetch_cnt_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t state;

  // rlast_i is not consulted: every read is single-beat, so any accepted
  // beat is treated as the last one.
  logic unused_rlast;
  assign unused_rlast = rlast_i;

  assign arid_o  = FETCH_ID;
  assign state_o = state;

  // pc_i is stable while im_done_o=0, which covers all of AR. This address
  // therefore meets AXI stability without a register of its own.
  assign araddr_o = arvalid_o ? {pc_i[ADDR_W-1:2], 2'b00} : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      arvalid_o   <= 1'b0;
      rready_o    <= 1'b0;
      inst_o      <= '0;
      im_done_o   <= 1'b0;
      im_err_o    <= 1'b0;
      fetch_cnt_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          arvalid_o <= 1'b1;
          state     <= ST_AR;
        end
        ST_AR: begin
          if (arready_i) begin
            arvalid_o <= 1'b0;
            rready_o  <= 1'b1;
            state     <= ST_R;
          end
        end
        ST_R: begin
          if (rvalid_i) begin
            rready_o    <= 1'b0;
            // Error responses feed a harmless NOP into the pipeline. The
            // error flag travels alongside it.
            inst_o      <= (rresp_i == 2'b00) ? rdata_i : NOP_INST;
            im_err_o    <= (rresp_i != 2'b00);
            im_done_o   <= 1'b1;
            fetch_cnt_o <= fetch_cnt_o + 32'd1;
            state       <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // The PC moves at this same edge. The next request therefore
          // presents the new pc_i one cycle later.
          if (pipe_adv_i) begin
            im_done_o <= 1'b0;
            im_err_o  <= 1'b0;
            arvalid_o <= 1'b1;
            state     <= ST_AR;
          end
        end
        default: begin
          arvalid_o <= 1'b0;
          rready_o  <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_master.sv
module tb_if_fetch_master;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [1:0]  S_AR = 2'd1, S_R = 2'd2, S_HOLD = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        pipe_adv_i;
  logic [3:0]  arid_o;
  logic [31:0] araddr_o;
  logic        arvalid_o;
  logic        arready_i;
  logic [31:0] rdata_i;
  logic [1:0]  rresp_i;
  logic        rlast_i;
  logic        rvalid_i;
  logic        rready_o;
  logic [31:0] inst_o;
  logic        im_done_o;
  logic        im_err_o;
  logic [31:0] fetch_cnt_o;
  logic [1:0]  state_o;

  int errors = 0;
  int checks = 0;
  logic [32:0] exp_q[$];      // {im_err, inst}
  logic [31:0] exp_cnt;
  logic [31:0] held;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  if_fetch_master dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .pipe_adv_i(pipe_adv_i),
    .arid_o(arid_o), .araddr_o(araddr_o), .arvalid_o(arvalid_o),
    .arready_i(arready_i), .rdata_i(rdata_i), .rresp_i(rresp_i),
    .rlast_i(rlast_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
    .inst_o(inst_o), .im_done_o(im_done_o), .im_err_o(im_err_o),
    .fetch_cnt_o(fetch_cnt_o), .state_o(state_o)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_arvalid"}, 64'(arvalid_o), 64'd0);
    check({tag, "_rready"},  64'(rready_o),  64'd0);
    check({tag, "_inst"},    64'(inst_o),    64'd0);
    check({tag, "_done"},    64'(im_done_o), 64'd0);
    check({tag, "_err"},     64'(im_err_o),  64'd0);
    check({tag, "_cnt"},     64'(fetch_cnt_o), 64'd0);
  endtask

  // ---------------- driver tasks ----------------
  // All driving and sampling happens at the falling edge.
  //
  // One complete fetch: wait for the request, stall arready for ar_wait
  // cycles, then return one beat after r_wait cycles. The expected beat is
  // pushed onto the queue when the beat is driven. It is popped when
  // im_done_o rises.
  task automatic do_fetch(input string tag, input int ar_wait, input int r_wait,
                          input logic [31:0] data, input logic [1:0] resp);
    int n;
    logic [31:0] exp_addr;
    logic [32:0] exp;
    exp_addr = {pc_i[31:2], 2'b00};
    n = 0;
    while (!arvalid_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_arvalid_seen"}, 64'(arvalid_o), 64'd1);
    check({tag, "_araddr"}, 64'(araddr_o), 64'(exp_addr));
    check({tag, "_arid"}, 64'(arid_o), 64'd0);
    for (int i = 0; i < ar_wait; i++) begin
      arready_i = 1'b0;
      @(negedge clk);
      check({tag, "_ar_stall_valid"}, 64'(arvalid_o), 64'd1);
      check({tag, "_ar_stall_addr"}, 64'(araddr_o), 64'(exp_addr));
      check({tag, "_ar_stall_done"}, 64'(im_done_o), 64'd0);
    end
    arready_i = 1'b1;
    @(negedge clk);
    arready_i = 1'b0;
    check({tag, "_r_rready"}, 64'(rready_o), 64'd1);
    check({tag, "_r_arvalid"}, 64'(arvalid_o), 64'd0);
    for (int i = 0; i < r_wait; i++) begin
      @(negedge clk);
      check({tag, "_r_wait_done"}, 64'(im_done_o), 64'd0);
      check({tag, "_r_wait_rready"}, 64'(rready_o), 64'd1);
    end
    rvalid_i = 1'b1;
    rdata_i  = data;
    rresp_i  = resp;
    exp_q.push_back({resp != 2'b00, (resp == 2'b00) ? data : NOP});
    exp_cnt  = exp_cnt + 32'd1;
    @(negedge clk);
    rvalid_i = 1'b0;
    rdata_i  = $urandom;
    rresp_i  = 2'b00;
    check({tag, "_done"}, 64'(im_done_o), 64'd1);
    check({tag, "_rready_low"}, 64'(rready_o), 64'd0);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_nonempty"}, 64'd0, 64'd1);
    end else begin
      exp = exp_q.pop_front();
      check({tag, "_inst"}, 64'(inst_o), 64'(exp[31:0]));
      check({tag, "_err"}, 64'(im_err_o), 64'(exp[32]));
    end
    check({tag, "_cnt"}, 64'(fetch_cnt_o), 64'(exp_cnt));
  endtask

  // Pipeline advance from HOLD; the IF stage moves pc_i at the same edge.
  task automatic advance(input string tag, input logic [31:0] new_pc);
    check({tag, "_adv_only_in_hold"}, 64'(state_o), 64'(S_HOLD));
    pipe_adv_i = 1'b1;
    pc_i       = new_pc;
    @(negedge clk);
    pipe_adv_i = 1'b0;
    check({tag, "_adv_done"}, 64'(im_done_o), 64'd0);
    check({tag, "_adv_err"}, 64'(im_err_o), 64'd0);
    check({tag, "_adv_arvalid"}, 64'(arvalid_o), 64'd1);
    check({tag, "_adv_araddr"}, 64'(araddr_o), 64'({new_pc[31:2], 2'b00}));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; pc_i = '0; pipe_adv_i = 1'b0; arready_i = 1'b0;
    rdata_i = '0; rresp_i = 2'b00; rlast_i = 1'b1; rvalid_i = 1'b0;
    exp_cnt = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // 1: minimum-latency fetch right after reset release
    rst = 1'b0;
    arready_i = 1'b1;
    @(negedge clk);                                  // cycle 1
    check("t1_arvalid_c1", 64'(arvalid_o), 64'd1);
    check("t1_araddr_c1", 64'(araddr_o), 64'd0);
    @(negedge clk);                                  // cycle 2
    arready_i = 1'b0;
    check("t1_rready_c2", 64'(rready_o), 64'd1);
    check("t1_done_c2", 64'(im_done_o), 64'd0);
    rvalid_i = 1'b1; rdata_i = 32'h0050_0093; rresp_i = 2'b00;
    exp_q.push_back({1'b0, 32'h0050_0093});
    exp_cnt = exp_cnt + 32'd1;
    @(negedge clk);                                  // cycle 3
    rvalid_i = 1'b0;
    check("t1_done_c3", 64'(im_done_o), 64'd1);
    check("t1_inst", 64'(inst_o), 64'(exp_q[0][31:0]));
    check("t1_err", 64'(im_err_o), 64'(exp_q[0][32]));
    void'(exp_q.pop_front());
    check("t1_cnt", 64'(fetch_cnt_o), 64'(exp_cnt));

    // 2: address channel stalled 5 cycles, unaligned-free PC 0x40
    advance("t2", 32'h40);
    do_fetch("t2", 5, 0, 32'h0010_0113, 2'b00);

    // 3: long HOLD with no advance
    held = inst_o;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t3_hold_inst", 64'(inst_o), 64'(held));
      check("t3_hold_done", 64'(im_done_o), 64'd1);
      check("t3_hold_arvalid", 64'(arvalid_o), 64'd0);
      check("t3_hold_rready", 64'(rready_o), 64'd0);
    end
    advance("t3", 32'h107);                          // low bits must be dropped
    do_fetch("t3", 0, 2, 32'hABCD_1234, 2'b00);

    // 4: error response substitutes a NOP and flags it until advance
    advance("t4", 32'h200);
    do_fetch("t4", 1, 1, 32'hDEAD_BEEF, 2'b10);
    check("t4_nop", 64'(inst_o), 64'(NOP));
    repeat (2) @(negedge clk);
    check("t4_err_held", 64'(im_err_o), 64'd1);
    advance("t4b", 32'h204);
    do_fetch("t4b", 0, 0, 32'h0000_0533, 2'b00);

    // randomised waits and data
    for (int k = 0; k < 6; k++) begin
      advance("rnd", 32'($urandom_range(0, 4095)));
      do_fetch("rnd", $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
               ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00);
    end

    // 5: asynchronous reset while a beat is pending in R
    advance("t5", 32'h300);
    arready_i = 1'b1;
    @(negedge clk);
    arready_i = 1'b0;
    check("t5_in_r", 64'(state_o), 64'(S_R));
    rvalid_i = 1'b1; rdata_i = 32'h1111_1111;
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("t5_async");
    @(negedge clk);
    rvalid_i = 1'b0;
    rst = 1'b0;
    exp_cnt = '0;
    @(negedge clk);
    check("t5_fresh_ar", 64'(arvalid_o), 64'd1);
    check("t5_cnt_zero", 64'(fetch_cnt_o), 64'd0);
    do_fetch("t5", 0, 0, 32'h2222_2222, 2'b00);

    // 6: counter wrap
    force dut.fetch_cnt_o = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.fetch_cnt_o;
    @(negedge clk);
    check("t6_preload", 64'(fetch_cnt_o), 64'hFFFF_FFFF);
    exp_cnt = 32'hFFFF_FFFF;
    advance("t6", 32'h400);
    do_fetch("t6", 0, 0, 32'h3333_3333, 2'b00);
    check("t6_wrap", 64'(fetch_cnt_o), 64'd0);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Overall time limit so that a stuck run still ends with a summary.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
